// File: rtl/ddr2_init_seq.sv
// DDR2 power-up initialisation sequencer: CKE hold-off, precharge/mode-register/refresh
// command train, DLL lock wait, then a sticky init_done level.
`ifndef DRAM_BA_WIDTH
`define DRAM_BA_WIDTH 3
`endif
`ifndef DRAM_ADDR_WIDTH
`define DRAM_ADDR_WIDTH 14
`endif

// state      | meaning
// CKE_LOW    | CKE held low, DESEL, waiting T_CKE_L
// CKE_NOP    | CKE raised, NOPs until first precharge-all
// PREA1      | first PREA issued, waiting T_RP
// EMRS2      | EMR2 loaded, waiting T_MRD
// EMRS3      | EMR3 loaded, waiting T_MRD
// EMRS1      | EMR1 loaded (DLL enable), waiting T_MRD
// MRS_DLLRST | MR loaded with DLL reset, DLL timer running, waiting T_MRD
// PREA2      | second PREA issued, waiting T_RP
// REF1       | first auto-refresh issued, waiting T_RFC
// REF2       | second auto-refresh issued, waiting T_RFC
// MRS        | MR loaded without DLL reset, waiting T_MRD
// OCD_DFLT   | EMR1 with OCD default issued, waiting T_MRD
// OCD_EXIT   | EMR1 with OCD exit issued, waiting T_MRD
// DLL_WAIT   | command train finished, waiting for DLL timer
// DONE       | init_done high, NOP forever
module ddr2_init_seq #(
  parameter int unsigned T_CKE_L   = 200,
  parameter int unsigned T_CKE_NOP = 80,
  parameter int unsigned T_RP      = 3,
  parameter int unsigned T_MRD     = 2,
  parameter int unsigned T_RFC     = 26,
  parameter int unsigned T_DLLK    = 200,
  parameter logic [12:0] MR_VAL    = 13'hA52,
  parameter logic [12:0] EMR1_VAL  = 13'h000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic                        cke,
  output logic                        cs_n,
  output logic                        ras_n,
  output logic                        cas_n,
  output logic                        we_n,
  output logic [`DRAM_BA_WIDTH-1:0]   ba,
  output logic [`DRAM_ADDR_WIDTH-1:0] addr,
  output logic                        odt,
  output logic                        init_done
);

  localparam int BAW = `DRAM_BA_WIDTH;
  localparam int AW  = `DRAM_ADDR_WIDTH;
  localparam int CW  = 16;

  localparam logic [3:0] CMD_DESEL = 4'b1111;
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_PREA  = 4'b0010;
  localparam logic [3:0] CMD_MRS   = 4'b0000;
  localparam logic [3:0] CMD_REF   = 4'b0001;

  typedef enum logic [3:0] {
    CKE_LOW, CKE_NOP, PREA1, EMRS2, EMRS3, EMRS1, MRS_DLLRST, PREA2,
    REF1, REF2, MRS, OCD_DFLT, OCD_EXIT, DLL_WAIT, DONE
  } state_t;

  state_t        state;
  logic          armed;
  logic [CW-1:0] cnt;
  logic [CW-1:0] dll_cnt;

  assign odt = 1'b0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                      <= CKE_LOW;
      armed                      <= 1'b0;
      cnt                        <= '0;
      dll_cnt                    <= '0;
      cke                        <= 1'b0;
      {cs_n, ras_n, cas_n, we_n} <= CMD_DESEL;
      ba                         <= '0;
      addr                       <= '0;
      init_done                  <= 1'b0;
    end else begin
      {cs_n, ras_n, cas_n, we_n} <= CMD_NOP;
      ba   <= '0;
      addr <= '0;
      if (cnt != '0)     cnt     <= cnt - 1'b1;
      if (dll_cnt != '0) dll_cnt <= dll_cnt - 1'b1;

      case (state)
        CKE_LOW: begin
          {cs_n, ras_n, cas_n, we_n} <= CMD_DESEL;
          // first released edge arms the hold-off timer; cycle 0 counts toward T_CKE_L
          if (!armed) begin
            armed <= 1'b1;
            cnt   <= CW'(T_CKE_L - 1);
          end else if (cnt == '0) begin
            cke                        <= 1'b1;
            {cs_n, ras_n, cas_n, we_n} <= CMD_NOP;
            state                      <= CKE_NOP;
            cnt                        <= CW'(T_CKE_NOP - 1);
          end
        end
        CKE_NOP: if (cnt == '0) begin
          {cs_n, ras_n, cas_n, we_n} <= CMD_PREA;
          addr  <= AW'(13'h400);
          state <= PREA1;
          cnt   <= CW'(T_RP - 1);
        end
        PREA1: if (cnt == '0) begin
          {cs_n, ras_n, cas_n, we_n} <= CMD_MRS;
          ba    <= BAW'(2);
          state <= EMRS2;
          cnt   <= CW'(T_MRD - 1);
        end
        EMRS2: if (cnt == '0) begin
          {cs_n, ras_n, cas_n, we_n} <= CMD_MRS;
          ba    <= BAW'(3);
          state <= EMRS3;
          cnt   <= CW'(T_MRD - 1);
        end
        EMRS3: if (cnt == '0) begin
          {cs_n, ras_n, cas_n, we_n} <= CMD_MRS;
          ba    <= BAW'(1);
          addr  <= AW'(EMR1_VAL);
          state <= EMRS1;
          cnt   <= CW'(T_MRD - 1);
        end
        EMRS1: if (cnt == '0) begin
          {cs_n, ras_n, cas_n, we_n} <= CMD_MRS;
          addr    <= AW'(MR_VAL | 13'h100);
          state   <= MRS_DLLRST;
          cnt     <= CW'(T_MRD - 1);
          dll_cnt <= CW'(T_DLLK - 1);
        end
        MRS_DLLRST: if (cnt == '0) begin
          {cs_n, ras_n, cas_n, we_n} <= CMD_PREA;
          addr  <= AW'(13'h400);
          state <= PREA2;
          cnt   <= CW'(T_RP - 1);
        end
        PREA2: if (cnt == '0) begin
          {cs_n, ras_n, cas_n, we_n} <= CMD_REF;
          state <= REF1;
          cnt   <= CW'(T_RFC - 1);
        end
        REF1: if (cnt == '0) begin
          {cs_n, ras_n, cas_n, we_n} <= CMD_REF;
          state <= REF2;
          cnt   <= CW'(T_RFC - 1);
        end
        REF2: if (cnt == '0) begin
          {cs_n, ras_n, cas_n, we_n} <= CMD_MRS;
          addr  <= AW'(MR_VAL);
          state <= MRS;
          cnt   <= CW'(T_MRD - 1);
        end
        MRS: if (cnt == '0) begin
          {cs_n, ras_n, cas_n, we_n} <= CMD_MRS;
          ba    <= BAW'(1);
          addr  <= AW'(EMR1_VAL | 13'h380);
          state <= OCD_DFLT;
          cnt   <= CW'(T_MRD - 1);
        end
        OCD_DFLT: if (cnt == '0) begin
          {cs_n, ras_n, cas_n, we_n} <= CMD_MRS;
          ba    <= BAW'(1);
          addr  <= AW'(EMR1_VAL);
          state <= OCD_EXIT;
          cnt   <= CW'(T_MRD - 1);
        end
        OCD_EXIT: if (cnt == '0) begin
          if (dll_cnt == '0) begin
            init_done <= 1'b1;
            state     <= DONE;
          end else begin
            state <= DLL_WAIT;
          end
        end
        DLL_WAIT: if (dll_cnt == '0) begin
          init_done <= 1'b1;
          state     <= DONE;
        end
        DONE: ;
        default: state <= CKE_LOW;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr2_init_seq.sv
// Scoreboard bench for ddr2_init_seq: default, short-DLL and all-ones timing instances
// run side by side, with reset pulses in DONE and mid-sequence.
`ifndef DRAM_BA_WIDTH
`define DRAM_BA_WIDTH 3
`endif
`ifndef DRAM_ADDR_WIDTH
`define DRAM_ADDR_WIDTH 14
`endif

module tb_ddr2_init_seq;

  localparam int BAW = `DRAM_BA_WIDTH;
  localparam int AW  = `DRAM_ADDR_WIDTH;
  localparam int VW  = 1 + 4 + BAW + AW + 2;

  localparam logic [3:0] C_NOP  = 4'b0111;
  localparam logic [3:0] C_PREA = 4'b0010;
  localparam logic [3:0] C_MRS  = 4'b0000;
  localparam logic [3:0] C_REF  = 4'b0001;

  typedef struct {
    int              cyc;
    logic [3:0]      cmd;
    logic [BAW-1:0]  ba;
    logic [AW-1:0]   addr;
  } ev_t;

  logic clk;
  logic rst_n;
  logic [2:0] cke, cs_n, ras_n, cas_n, we_n, odt, init_done;
  logic [BAW-1:0] ba   [3];
  logic [AW-1:0]  addr [3];

  int checks   = 0;
  int failures = 0;

  ev_t q0[$];
  ev_t q1[$];
  ev_t q2[$];

  int cke_l   [3] = '{200, 200, 1};
  int done_at [3] = '{489, 352, 13};
  int dflt_cyc[11] = '{280, 283, 285, 287, 289, 291, 294, 320, 346, 348, 350};
  logic [3:0]     cmd_tab [11] = '{C_PREA, C_MRS, C_MRS, C_MRS, C_MRS, C_PREA,
                                   C_REF, C_REF, C_MRS, C_MRS, C_MRS};
  logic [BAW-1:0] ba_tab  [11] = '{0, 2, 3, 1, 0, 0, 0, 0, 0, 1, 1};
  logic [AW-1:0]  addr_tab[11] = '{'h400, 'h000, 'h000, 'h000, 'hB52, 'h400,
                                   'h000, 'h000, 'hA52, 'h380, 'h000};

  ddr2_init_seq u_dflt (
    .clk(clk), .rst_n(rst_n), .cke(cke[0]), .cs_n(cs_n[0]), .ras_n(ras_n[0]),
    .cas_n(cas_n[0]), .we_n(we_n[0]), .ba(ba[0]), .addr(addr[0]), .odt(odt[0]),
    .init_done(init_done[0]));

  ddr2_init_seq #(.T_DLLK(10)) u_dll10 (
    .clk(clk), .rst_n(rst_n), .cke(cke[1]), .cs_n(cs_n[1]), .ras_n(ras_n[1]),
    .cas_n(cas_n[1]), .we_n(we_n[1]), .ba(ba[1]), .addr(addr[1]), .odt(odt[1]),
    .init_done(init_done[1]));

  ddr2_init_seq #(.T_CKE_L(1), .T_CKE_NOP(1), .T_RP(1), .T_MRD(1), .T_RFC(1),
                  .T_DLLK(1)) u_ones (
    .clk(clk), .rst_n(rst_n), .cke(cke[2]), .cs_n(cs_n[2]), .ras_n(ras_n[2]),
    .cas_n(cas_n[2]), .we_n(we_n[2]), .ba(ba[2]), .addr(addr[2]), .odt(odt[2]),
    .init_done(init_done[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_ev(input int i, input ev_t e);
    case (i)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic pop_exp(input int i, input int c, output logic hit, output ev_t e);
    hit = 1'b0;
    e   = '{cyc: 0, cmd: C_NOP, ba: '0, addr: '0};
    case (i)
      0: if (q0.size() > 0 && q0[0].cyc == c) begin e = q0.pop_front(); hit = 1'b1; end
      1: if (q1.size() > 0 && q1[0].cyc == c) begin e = q1.pop_front(); hit = 1'b1; end
      default: if (q2.size() > 0 && q2[0].cyc == c) begin e = q2.pop_front(); hit = 1'b1; end
    endcase
  endtask

  task automatic push_all();
    ev_t e;
    q0.delete(); q1.delete(); q2.delete();
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 11; k++) begin
        e.cyc  = (i == 2) ? 2 + k : dflt_cyc[k];
        e.cmd  = cmd_tab[k];
        e.ba   = ba_tab[k];
        e.addr = addr_tab[k];
        push_ev(i, e);
      end
    end
  endtask

  function automatic logic [VW-1:0] obs_vec(input int i, input logic [AW-1:0] mask);
    return {cke[i], cs_n[i], ras_n[i], cas_n[i], we_n[i], ba[i], addr[i] & mask,
            odt[i], init_done[i]};
  endfunction

  task automatic check_reset();
    logic [VW-1:0] exp_v;
    exp_v = {1'b0, 4'b1111, {BAW{1'b0}}, {AW{1'b0}}, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      checks++;
      assert (obs_vec(i, {AW{1'b1}}) === exp_v) else begin
        failures++;
        $error("FAIL reset_vals inst=%0d observed=%h expected=%h", i,
               obs_vec(i, {AW{1'b1}}), exp_v);
      end
    end
  endtask

  task automatic check_cycle(input int c);
    logic          hit;
    ev_t           e;
    logic [AW-1:0] mask;
    logic [VW-1:0] exp_v;
    logic [3:0]    obs4;
    for (int i = 0; i < 3; i++) begin
      pop_exp(i, c, hit, e);
      if (c < cke_l[i]) begin
        obs4 = {cke[i], cs_n[i], odt[i], init_done[i]};
        checks++;
        assert (obs4 === 4'b0100) else begin
          failures++;
          $error("FAIL cke_low inst=%0d cyc=%0d observed=%h expected=%h", i, c, obs4, 4'b0100);
        end
      end else begin
        mask  = (hit && e.cmd == C_PREA) ? AW'(14'h0400) : {AW{1'b1}};
        exp_v = {1'b1, e.cmd, e.ba, e.addr & mask, 1'b0, (c >= done_at[i]) ? 1'b1 : 1'b0};
        checks++;
        assert (obs_vec(i, mask) === exp_v) else begin
          failures++;
          $error("FAIL cmd_cycle inst=%0d cyc=%0d observed=%h expected=%h", i, c,
                 obs_vec(i, mask), exp_v);
        end
      end
    end
  endtask

  task automatic run(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      check_cycle(c);
    end
  endtask

  // assert reset at a falling edge, check the next registered values, release
  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    check_reset();
    rst_n = 1'b1;
    push_all();
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset();
    rst_n = 1'b1;
    push_all();
    run(500);
    pulse_reset();
    run(300);
    pulse_reset();
    run(500);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ddr2_init_seq.md
DDR2_INIT_SEQ -- requirements
Module: ddr2_init_seq

Interface
REQ-001 SHALL have parameter T_CKE_L, default 200, cycles CKE held low after reset release.
REQ-002 SHALL have parameter T_CKE_NOP, default 80, NOP cycles between CKE rise and first PREA.
REQ-003 SHALL have parameters T_RP, T_MRD, T_RFC, T_DLLK, defaults 3, 2, 26, 200; command-to-command spacing in cycles.
REQ-004 SHALL have parameters MR_VAL, default 13'hA52 (WR=6, CL=5, sequential, BL4), and EMR1_VAL, default 13'h000 (DLL on, full drive, Rtt off, AL=0).
REQ-005 clk  input  1  controller clock; all logic on rising edge.
REQ-006 rst_n  input  1  synchronous, active-low reset.
REQ-007 cke, cs_n, ras_n, cas_n, we_n  output  1 each  DRAM command pins, registered.
REQ-008 ba  output  `DRAM_BA_WIDTH  bank/mode-register select, registered.
REQ-009 addr  output  `DRAM_ADDR_WIDTH  address/mode value, registered; bits above 12 driven 0.
REQ-010 odt  output  1  constant 0.
REQ-011 init_done  output  1  level, high once sequence complete.

Function
REQ-012 Cycle 0 SHALL be the first rising edge with rst_n sampled high; "at cycle k" means the value registered at that edge.
REQ-013 Encodings: DESEL cs_n=1; NOP 0/1/1/1; PREA 0/0/1/0 with addr[10]=1; MRS/EMRS 0/0/0/0; REF 0/0/0/1 (cs_n/ras_n/cas_n/we_n).
REQ-014 Every command SHALL last exactly one cycle; all other cycles after CKE rise SHALL be NOP with ba=0, addr=0.
REQ-015 Cycles 0..T_CKE_L-1: cke=0, DESEL.
REQ-016 At cycle T_CKE_L: cke=1, NOP; cke SHALL stay 1 until reset.
REQ-017 Sequence, command i+1 issued exactly T after command i where T is the spacing listed after command i: PREA at T_CKE_L+T_CKE_NOP (T_RP); EMRS2 ba=2 addr=0 (T_MRD); EMRS3 ba=3 addr=0 (T_MRD); EMRS1 ba=1 addr=EMR1_VAL (T_MRD); MRS ba=0 addr=MR_VAL|13'h100 (T_MRD); PREA (T_RP); REF (T_RFC); REF (T_RFC); MRS ba=0 addr=MR_VAL (T_MRD); EMRS1 addr=EMR1_VAL|13'h380 (T_MRD); EMRS1 addr=EMR1_VAL (T_MRD).
REQ-018 A single down-counter SHALL time spacing: loaded with T-1 on command issue, next command issued the cycle after it reads 0.
REQ-019 A separate DLL counter SHALL start at the DLL-reset MRS; init_done SHALL rise at cycle max(last EMRS1 + T_MRD, DLL-reset MRS + T_DLLK).
REQ-020 States: CKE_LOW, CKE_NOP, PREA1, EMRS2, EMRS3, EMRS1, MRS_DLLRST, PREA2, REF1, REF2, MRS, OCD_DFLT, OCD_EXIT, DLL_WAIT, DONE; DONE absorbing.
REQ-021 In DONE: init_done=1, cke=1, NOP, no further commands.
REQ-022 Parameters of 1 SHALL give back-to-back commands on consecutive cycles; value 0 is illegal.

Reset
REQ-023 While rst_n sampled low: cke=0, cs_n=1, ras_n=1, cas_n=1, we_n=1, ba=0, addr=0, odt=0, init_done=0, state CKE_LOW, counters 0.
REQ-024 Reset asserted at any point, including DONE, SHALL take effect at the next edge and restart the full sequence at release.

Verification
REQ-025 Defaults, release reset -> cke=0 cycles 0-199; cke=1 cycle 200; PREA cycle 280; EMRS2 283; EMRS3 285; EMRS1 addr=0 287; MRS addr=0xB52 289.
REQ-026 Defaults continued -> PREA 291; REF 294; REF 320; MRS addr=0xA52 346; EMRS1 addr=0x380 348; EMRS1 addr=0 350; init_done=1 at 489, not before.
REQ-027 T_DLLK=10, others default -> init_done=1 at cycle 352 (T_MRD-bound).
REQ-028 Reset pulsed at cycle 300 -> next edge all outputs at reset values; after release cke low again for 200 cycles, PREA at release+280.
REQ-029 All timing parameters 1, T_CKE_L=T_CKE_NOP=1 -> PREA at cycle 2, eleven commands on cycles 2-12, no NOP between.
REQ-030 Any run -> at most one of PREA/MRS/REF per cycle, odt always 0, ba=0 on PREA/REF cycles.
